// File: rtl/encrypt_seq_ctrl.sv
// LFSR message-encryption sequencer: loads run config from DM, encrypts 64 slots into DM[OUT_BASE+i].
// Define LFSR_RAW_TAPS_EN to load the tap mask straight from DM instead of the pattern table.
module encrypt_seq_ctrl #(
  parameter logic [7:0] MSG_BASE  = 8'd0,
  parameter logic [7:0] PRE_ADDR  = 8'd61,
  parameter logic [7:0] PTN_ADDR  = 8'd62,
  parameter logic [7:0] SEED_ADDR = 8'd63,
  parameter logic [7:0] OUT_BASE  = 8'd64,
  parameter logic [6:0] NUM_BYTES = 7'd64,
  parameter logic [7:0] PRE_MIN   = 8'd10,
  parameter logic [7:0] PRE_MAX   = 8'd26
) (
  input  logic       clk,
  input  logic       init,
  input  logic       req,
  output logic       ack,
  output logic [7:0] dm_addr,
  output logic       dm_wr_en,
  output logic [7:0] dm_wdata,
  input  logic [7:0] dm_rdata
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LD_PRE  = 3'd1;
  localparam logic [2:0] LD_PTN  = 3'd2;
  localparam logic [2:0] LD_SEED = 3'd3;
  localparam logic [2:0] RD      = 3'd4;
  localparam logic [2:0] WR      = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  function automatic logic even_parity(input logic [6:0] v);
    return ^v;
  endfunction

  function automatic logic [7:0] encode(input logic [7:0] b, input logic [6:0] l);
    logic [7:0] x;
    x = b ^ {1'b0, l};
    return {even_parity(x[6:0]), x[6:0]};
  endfunction

  function automatic logic [7:0] clamp_pre(input logic [7:0] v);
    if (v < PRE_MIN) begin
      return PRE_MIN;
    end else if (v > PRE_MAX) begin
      return PRE_MAX;
    end else begin
      return v;
    end
  endfunction

`ifdef LFSR_RAW_TAPS_EN
  function automatic logic [6:0] decode_taps(input logic [6:0] s);
    return (s == 7'h00) ? 7'h60 : s;
  endfunction
`else
  function automatic logic [6:0] decode_taps(input logic [7:0] s);
    logic [3:0] idx;
    idx = (s == 8'd8) ? 4'd8 : {1'b0, s[2:0]};
    case (idx)
      4'd0:    return 7'h60;
      4'd1:    return 7'h48;
      4'd2:    return 7'h78;
      4'd3:    return 7'h72;
      4'd4:    return 7'h6A;
      4'd5:    return 7'h69;
      4'd6:    return 7'h5C;
      4'd7:    return 7'h7E;
      4'd8:    return 7'h7B;
      default: return 7'h60;
    endcase
  endfunction
`endif

  logic [2:0] state_q, state_d;
  logic [6:0] i_q, i_d;
  logic [7:0] pre_q, pre_d;
  logic [6:0] taps_q, taps_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic [7:0] byte_q, byte_d;
  logic       req_q, req_d;
  logic       ack_q, ack_d;
  logic       wr_q, wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] slot_s;

  // Next-state and datapath updates for the sequencer FSM.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    pre_d   = pre_q;
    taps_d  = taps_q;
    lfsr_d  = lfsr_q;
    byte_d  = byte_q;
    req_d   = req;
    case (state_q)
      IDLE: begin
        if (req_q && !req) begin
          state_d = LD_PRE;
        end else begin
          state_d = IDLE;
        end
      end
      LD_PRE: begin
        pre_d   = clamp_pre(dm_rdata);
        state_d = LD_PTN;
      end
      LD_PTN: begin
`ifdef LFSR_RAW_TAPS_EN
        taps_d  = decode_taps(dm_rdata[6:0]);
`else
        taps_d  = decode_taps(dm_rdata);
`endif
        state_d = LD_SEED;
      end
      LD_SEED: begin
        lfsr_d  = (dm_rdata[6:0] == 7'h00) ? 7'h01 : dm_rdata[6:0];
        i_d     = 7'd0;
        state_d = RD;
      end
      RD: begin
        byte_d  = ({1'b0, i_q} >= pre_q) ? dm_rdata : 8'h20;
        state_d = WR;
      end
      WR: begin
        lfsr_d = {lfsr_q[5:0], ^(lfsr_q & taps_q)};
        i_d    = i_q + 7'd1;
        if (i_q == NUM_BYTES - 7'd1) begin
          state_d = DONE;
        end else begin
          state_d = RD;
        end
      end
      DONE: begin
        if (req) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    ack_d   = (state_d == DONE);
    wr_d    = (state_d == WR);
    slot_s  = {1'b0, i_d};
    wdata_d = 8'h00;
    case (state_d)
      LD_PRE:  addr_d = PRE_ADDR;
      LD_PTN:  addr_d = PTN_ADDR;
      LD_SEED: addr_d = SEED_ADDR;
      RD: begin
        if (slot_s >= pre_d) begin
          addr_d = MSG_BASE + (slot_s - pre_d);
        end else begin
          addr_d = 8'd0;
        end
      end
      WR: begin
        addr_d  = OUT_BASE + slot_s;
        wdata_d = encode(byte_d, lfsr_d);
      end
      default: addr_d = 8'd0;
    endcase
  end

  // State and output registers with synchronous init.
  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= IDLE;
      i_q     <= 7'd0;
      pre_q   <= 8'd0;
      taps_q  <= 7'd0;
      lfsr_q  <= 7'd0;
      byte_q  <= 8'd0;
      req_q   <= 1'b1;
      ack_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      pre_q   <= pre_d;
      taps_q  <= taps_d;
      lfsr_q  <= lfsr_d;
      byte_q  <= byte_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // init suppresses the write on the very edge it is sampled.
  assign dm_wr_en = wr_q & ~init;
  assign ack      = ack_q;
  assign dm_addr  = addr_q;
  assign dm_wdata = wdata_q;

endmodule

// File: tb/tb_encrypt_seq_ctrl.sv
// Directed bench for encrypt_seq_ctrl: config vectors table plus init-abort and relaunch sequences.
module tb_encrypt_seq_ctrl;

  logic       clk = 1'b0;
  logic       init;
  logic       req;
  logic       ack;
  logic [7:0] dm_addr;
  logic       dm_wr_en;
  logic [7:0] dm_wdata;
  logic [7:0] dm_rdata;

  logic [7:0] dm [0:255];
  logic [7:0] wr_addr_log [0:1023];
  logic [7:0] wr_data_log [0:1023];
  int         wr_cnt = 0;
  logic [7:0] exp_out [0:63];
  int         total = 0;
  int         bad = 0;

  typedef struct {
    logic [7:0] pre;
    logic [7:0] ptn;
    logic [7:0] seed;
    logic [7:0] exp64;
    logic [7:0] exp65;
    logic [7:0] xaddr;
    logic [7:0] xval;
  } vec_t;

  vec_t vecs [6];

  encrypt_seq_ctrl dut (
    .clk      (clk),
    .init     (init),
    .req      (req),
    .ack      (ack),
    .dm_addr  (dm_addr),
    .dm_wr_en (dm_wr_en),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata)
  );

  always #5 clk = ~clk;

  assign dm_rdata = dm[dm_addr];

  always @(posedge clk) begin
    if (dm_wr_en) begin
      wr_addr_log[wr_cnt] <= dm_addr;
      wr_data_log[wr_cnt] <= dm_wdata;
      wr_cnt              <= wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] model_taps(input logic [7:0] s);
`ifdef LFSR_RAW_TAPS_EN
    return (s[6:0] == 7'h00) ? 7'h60 : s[6:0];
`else
    logic [6:0] tbl [0:8];
    tbl = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
    if (s == 8'd8) return tbl[8];
    return tbl[s[2:0]];
`endif
  endfunction

  task automatic prepare(input vec_t v);
    int         pre;
    logic [6:0] taps;
    logic [6:0] l;
    logic [7:0] b;
    logic [7:0] x;
    dm[61] = v.pre;
    dm[62] = v.ptn;
    dm[63] = v.seed;
    pre  = (v.pre < 8'd10) ? 10 : ((v.pre > 8'd26) ? 26 : int'(v.pre));
    taps = model_taps(v.ptn);
    l    = (v.seed[6:0] == 7'h00) ? 7'h01 : v.seed[6:0];
    for (int k = 0; k < 64; k++) begin
      b = (k >= pre) ? dm[k - pre] : 8'h20;
      x = b ^ {1'b0, l};
      exp_out[k] = {^x[6:0], x[6:0]};
      l = {l[5:0], ^(l & taps)};
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int base;
    int got;
    int errs;
    prepare(v);
    @(negedge clk) req = 1'b1;
    @(posedge clk) #1;
    chk({tag, "_ack_low_after_req"}, ack, 0);
    @(negedge clk);
    base = wr_cnt;
    req  = 1'b0;
    // Edge 1 is the launch edge; ack is expected right after edge 132.
    got = 0;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk) #1;
      if (ack) begin
        got = e;
        break;
      end
    end
    chk({tag, "_ack_latency"}, got, 132);
    repeat (3) @(negedge clk);
    chk({tag, "_ack_held"}, ack, 1);
    chk({tag, "_write_count"}, wr_cnt - base, 64);
    errs = 0;
    for (int k = 0; k < 64; k++) begin
      if (wr_addr_log[base + k] !== 8'(64 + k)) errs++;
      if (wr_data_log[base + k] !== exp_out[k]) errs++;
    end
    chk({tag, "_model_bytes"}, errs, 0);
    chk({tag, "_dm64"}, wr_data_log[base], v.exp64);
    chk({tag, "_dm65"}, wr_data_log[base + 1], v.exp65);
    if (v.xaddr != 8'd0) begin
      chk({tag, "_dm_extra"}, wr_data_log[base + int'(v.xaddr) - 64], v.xval);
    end
  endtask

  initial begin
    string msg;
    int    base;
    int    seen;
    msg = "Mr. Watson, come here. I want to see you.";
    for (int k = 0; k < 256; k++) dm[k] = 8'h00;
    for (int k = 0; k < 61; k++) dm[k] = (k < msg.len()) ? msg[k] : 8'h20;

    vecs[0] = '{8'd5,   8'h00, 8'h01, 8'h21, 8'h22, 8'd74, 8'h55};
    vecs[1] = '{8'd5,   8'h00, 8'h00, 8'h21, 8'h22, 8'd74, 8'h55};
`ifdef LFSR_RAW_TAPS_EN
    vecs[2] = '{8'd12,  8'h08, 8'h55, 8'hF5, 8'h0A, 8'd0,  8'h00};
    vecs[3] = '{8'd30,  8'h0D, 8'hFF, 8'h5F, 8'h5F, 8'd0,  8'h00};
    vecs[4] = '{8'd40,  8'h08, 8'h00, 8'h21, 8'h22, 8'd0,  8'h00};
`else
    vecs[2] = '{8'd12,  8'h08, 8'h55, 8'hF5, 8'h8B, 8'd0,  8'h00};
    vecs[3] = '{8'd30,  8'h0D, 8'hFF, 8'h5F, 8'hDE, 8'd0,  8'h00};
    vecs[4] = '{8'd40,  8'h08, 8'h00, 8'h21, 8'hA3, 8'd0,  8'h00};
`endif
    vecs[5] = '{8'h80,  8'h48, 8'h01, 8'h21, 8'h22, 8'd0,  8'h00};

    init = 1'b1;
    req  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", ack, 0);
    chk("reset_wr_en", dm_wr_en, 0);
    chk("reset_addr", dm_addr, 0);
    chk("reset_wdata", dm_wdata, 0);
    @(negedge clk) init = 1'b0;

    for (int n = 0; n < 6; n++) begin
      run_vec(vecs[n], $sformatf("vec%0d", n));
    end

    // Abort with init on the write of slot 20, then relaunch.
    prepare(vecs[0]);
    @(negedge clk) req = 1'b1;
    @(negedge clk);
    base = wr_cnt;
    req  = 1'b0;
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (dm_wr_en && dm_addr == 8'd84) begin
        seen = 1;
        break;
      end
    end
    chk("abort_reached_slot20", seen, 1);
    init = 1'b1;
    @(posedge clk) #1;
    chk("abort_no_write", wr_cnt - base, 20);
    chk("abort_ack", ack, 0);
    chk("abort_addr", dm_addr, 0);
    chk("abort_wdata", dm_wdata, 0);
    @(negedge clk) init = 1'b0;
    req = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle_no_writes", wr_cnt - base, 20);
    run_vec(vecs[0], "relaunch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
